// File: rtl/timing_gen.sv
// Clock-enable, interrupt, NMI and watchdog strobe generator for the vector arcade cores.
// All strobes are decoded from free-running registered counters on the single system clock.
module timing_gen #(
    parameter int CPU_DIV       = 8,
    parameter int VEC_RATIO     = 2,
    parameter int TICK_DIV      = 8192,
    parameter int AUD_DIV       = 4096,
    parameter int NMI_PERIOD    = 14,
    parameter int NMI_WIDTH     = 1,
    parameter int WDOG_TICKS    = 0,
    parameter int WDOG_RST_CLKS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_stall,
    input  logic wdog_clr,
    output logic cpu_en,
    output logic cpu_phase,
    output logic vec_en,
    output logic tick_en,
    output logic aud_en,
    output logic nmi,
    output logic core_rst,
    output logic wdog_rst
);

    localparam int CPU_W   = $clog2(CPU_DIV);
    localparam int TICK_W  = $clog2(TICK_DIV);
    localparam int AUD_W   = $clog2(AUD_DIV);
    localparam int NMI_W   = $clog2(NMI_PERIOD);
    localparam int VEC_DIV = CPU_DIV / VEC_RATIO;

    logic [CPU_W-1:0]  cpu_cnt_q,  cpu_cnt_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [AUD_W-1:0]  aud_cnt_q,  aud_cnt_d;
    logic [NMI_W-1:0]  nmi_cnt_q,  nmi_cnt_d;
    logic              nmi_q,      nmi_d;
    logic              core_rst_q, core_rst_d;
    logic              cpu_tc;
    logic              nmi_win;
    logic              wd_fire;
    logic              wdog_rst_q;
    logic [VEC_RATIO-1:0] vec_hit;

    assign cpu_tc    = (cpu_cnt_q == CPU_W'(CPU_DIV - 1));
    assign cpu_en    = cpu_tc & ~cpu_stall;
    assign cpu_phase = (cpu_cnt_q >= CPU_W'(CPU_DIV / 2));
    assign tick_en   = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign aud_en    = (aud_cnt_q == AUD_W'(AUD_DIV - 1));

    // vec_en fires at the last count of each of the VEC_RATIO sub-periods of a CPU cycle
    genvar gi;
    generate
        for (gi = 0; gi < VEC_RATIO; gi++) begin : gen_vec
            assign vec_hit[gi] = (cpu_cnt_q == CPU_W'(gi * VEC_DIV + VEC_DIV - 1));
        end
    endgenerate
    assign vec_en = |vec_hit;

    assign nmi_win = (nmi_cnt_q >= NMI_W'(NMI_PERIOD - 1 - NMI_WIDTH)) &&
                     (nmi_cnt_q <  NMI_W'(NMI_PERIOD - 1));

    always_comb begin
        cpu_cnt_d  = cpu_tc  ? '0 : cpu_cnt_q + CPU_W'(1);
        tick_cnt_d = tick_en ? '0 : tick_cnt_q + TICK_W'(1);
        aud_cnt_d  = aud_en  ? '0 : aud_cnt_q + AUD_W'(1);

        nmi_cnt_d = nmi_cnt_q;
        nmi_d     = nmi_q;
        if (wd_fire) begin
            nmi_cnt_d = '0;
            nmi_d     = 1'b0;
        end else if (tick_en) begin
            nmi_cnt_d = (nmi_cnt_q == NMI_W'(NMI_PERIOD - 1)) ? '0 : nmi_cnt_q + NMI_W'(1);
            nmi_d     = nmi_win;
        end

        // Release happens at a CPU cycle boundary; a new watchdog firing re-arms it first
        core_rst_d = core_rst_q;
        if (wd_fire || wdog_rst_q) begin
            core_rst_d = 1'b1;
        end else if (cpu_tc) begin
            core_rst_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_cnt_q  <= '0;
            tick_cnt_q <= '0;
            aud_cnt_q  <= '0;
            nmi_cnt_q  <= '0;
            nmi_q      <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            cpu_cnt_q  <= cpu_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            aud_cnt_q  <= aud_cnt_d;
            nmi_cnt_q  <= nmi_cnt_d;
            nmi_q      <= nmi_d;
            core_rst_q <= core_rst_d;
        end
    end

    generate
        if (WDOG_TICKS > 0) begin : gen_wdog
            localparam int WD_W  = (WDOG_TICKS > 1) ? $clog2(WDOG_TICKS) : 1;
            localparam int PLS_W = $clog2(WDOG_RST_CLKS + 1);

            logic [WD_W-1:0]  wd_cnt_q,  wd_cnt_d;
            logic [PLS_W-1:0] pls_cnt_q, pls_cnt_d;
            logic             wdog_rst_d;

            // A clear in the same cycle as the final tick suppresses the firing
            assign wd_fire = tick_en & ~wdog_clr & (wd_cnt_q == WD_W'(WDOG_TICKS - 1));

            always_comb begin
                wd_cnt_d   = wd_cnt_q;
                pls_cnt_d  = pls_cnt_q;
                wdog_rst_d = wdog_rst_q;
                if (wdog_clr || wd_fire) begin
                    wd_cnt_d = '0;
                end else if (tick_en) begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
                if (wd_fire) begin
                    wdog_rst_d = 1'b1;
                    pls_cnt_d  = PLS_W'(WDOG_RST_CLKS - 1);
                end else if (wdog_rst_q) begin
                    if (pls_cnt_q == '0) begin
                        wdog_rst_d = 1'b0;
                    end else begin
                        pls_cnt_d = pls_cnt_q - PLS_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wd_cnt_q   <= '0;
                    pls_cnt_q  <= '0;
                    wdog_rst_q <= 1'b0;
                end else begin
                    wd_cnt_q   <= wd_cnt_d;
                    pls_cnt_q  <= pls_cnt_d;
                    wdog_rst_q <= wdog_rst_d;
                end
            end
        end else begin : gen_no_wdog
            logic unused_wdog_clr;
            assign unused_wdog_clr = wdog_clr;
            assign wd_fire         = 1'b0;
            assign wdog_rst_q      = 1'b0;
        end
    endgenerate

    assign nmi      = nmi_q;
    assign core_rst = core_rst_q;
    assign wdog_rst = wdog_rst_q;

endmodule
